// File: rtl/turbo_encoder_ctrl_if.sv
// rtl/turbo_encoder_ctrl_if.sv - code block request and d0/d1/d2 stream bundle for the turbo encoder controller
interface turbo_encoder_ctrl_if #(
    parameter int K  = 40,
    parameter int AW = $clog2(K + 4)
);
    logic          start;
    logic [0:K-1]  din;
    logic          ready;
    logic          d_valid;
    logic          d0;
    logic          d1;
    logic          d2;
    logic [AW-1:0] d_idx;
    logic          done;

    modport master (
        output start, din,
        input  ready, d_valid, d0, d1, d2, d_idx, done
    );

    modport slave (
        input  start, din,
        output ready, d_valid, d0, d1, d2, d_idx, done
    );
endinterface

// File: rtl/turbo_encoder_ctrl.sv
// rtl/turbo_encoder_ctrl.sv - rate 1/3 PCCC turbo encoder sequencer with on-the-fly QPP addressing
module turbo_encoder_ctrl #(
    parameter int K  = 40,
    parameter int F1 = 3,
    parameter int F2 = 10,
    parameter int AW = $clog2(K + 4)
) (
    input  logic clk,
    input  logic rst,
    turbo_encoder_ctrl_if.slave bus
);
    localparam int            IW     = $clog2(K);
    localparam logic [AW:0]   K_W    = (AW + 1)'(K);
    localparam logic [AW-1:0] G_INIT = AW'((F1 + F2) % K);
    localparam logic [AW-1:0] G_STEP = AW'((2 * F2) % K);

    typedef enum logic [1:0] {IDLE, ENCODE, TAIL, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [0:K-1]  blk_q, blk_d;
    logic [AW-1:0] i_q, i_d, pi_q, pi_d, g_q, g_d;
    // Encoder state packing: bit0 = s1, bit1 = s2, bit2 = s3.
    logic [2:0]    enc1_q, enc1_d, enc2_q, enc2_d;
    // Tail register (4 x 3 bits): termination bit t sits at position 2-t.
    logic [2:0]    tx1_q, tx1_d, tz1_q, tz1_d, tx2_q, tx2_d, tz2_q, tz2_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d, d_valid_q, d_valid_d, done_q, done_d;
    logic          d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic [AW-1:0] d_idx_q, d_idx_d;
    logic          c1, c2, a1, a2, z1, z2;

    // (a + b) mod K for operands already below K: a single conditional subtract.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= K_W) begin
            sum = sum - K_W;
        end
        return sum[AW-1:0];
    endfunction

    // Next-state, interleaver recursion, constituent encoders and registered stream outputs.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        i_d       = i_q;
        pi_d      = pi_q;
        g_d       = g_q;
        enc1_d    = enc1_q;
        enc2_d    = enc2_q;
        tx1_d     = tx1_q;
        tz1_d     = tz1_q;
        tx2_d     = tx2_q;
        tz2_d     = tz2_q;
        cnt_d     = cnt_q;
        d_valid_d = 1'b0;
        d0_d      = 1'b0;
        d1_d      = 1'b0;
        d2_d      = 1'b0;
        d_idx_d   = '0;
        done_d    = 1'b0;
        c1        = blk_q[i_q[IW-1:0]];
        c2        = blk_q[pi_q[IW-1:0]];
        a1        = c1 ^ enc1_q[1] ^ enc1_q[2];
        a2        = c2 ^ enc2_q[1] ^ enc2_q[2];
        z1        = a1 ^ enc1_q[0] ^ enc1_q[2];
        z2        = a2 ^ enc2_q[0] ^ enc2_q[2];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    blk_d   = bus.din;
                    enc1_d  = '0;
                    enc2_d  = '0;
                    i_d     = '0;
                    pi_d    = '0;
                    g_d     = G_INIT;
                    cnt_d   = '0;
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                enc1_d    = {enc1_q[1], enc1_q[0], a1};
                enc2_d    = {enc2_q[1], enc2_q[0], a2};
                d_valid_d = 1'b1;
                d0_d      = c1;
                d1_d      = z1;
                d2_d      = z2;
                d_idx_d   = i_q;
                pi_d      = mod_add(pi_q, g_q);
                g_d       = mod_add(g_q, G_STEP);
                i_d       = i_q + AW'(1);
                if (i_q == AW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = TAIL;
                end
            end
            TAIL: begin
                // Feeding c = s2^s3 forces a = 0, so three shifts drain each state to 000.
                tx1_d  = {tx1_q[1:0], enc1_q[1] ^ enc1_q[2]};
                tz1_d  = {tz1_q[1:0], enc1_q[0] ^ enc1_q[2]};
                tx2_d  = {tx2_q[1:0], enc2_q[1] ^ enc2_q[2]};
                tz2_d  = {tz2_q[1:0], enc2_q[0] ^ enc2_q[2]};
                enc1_d = {enc1_q[1], enc1_q[0], 1'b0};
                enc2_d = {enc2_q[1], enc2_q[0], 1'b0};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                d_valid_d = 1'b1;
                d_idx_d   = AW'(K) + AW'(cnt_q);
                cnt_d     = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0:    begin d0_d = tx1_q[2]; d1_d = tz1_q[2]; d2_d = tx1_q[1]; end
                    2'd1:    begin d0_d = tz1_q[1]; d1_d = tx1_q[0]; d2_d = tz1_q[0]; end
                    2'd2:    begin d0_d = tx2_q[2]; d1_d = tz2_q[2]; d2_d = tx2_q[1]; end
                    default: begin
                        d0_d    = tz2_q[1];
                        d1_d    = tx2_q[0];
                        d2_d    = tz2_q[0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers; reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            blk_q     <= '0;
            i_q       <= '0;
            pi_q      <= '0;
            g_q       <= '0;
            enc1_q    <= '0;
            enc2_q    <= '0;
            tx1_q     <= '0;
            tz1_q     <= '0;
            tx2_q     <= '0;
            tz2_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            d_valid_q <= 1'b0;
            d0_q      <= 1'b0;
            d1_q      <= 1'b0;
            d2_q      <= 1'b0;
            d_idx_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            i_q       <= i_d;
            pi_q      <= pi_d;
            g_q       <= g_d;
            enc1_q    <= enc1_d;
            enc2_q    <= enc2_d;
            tx1_q     <= tx1_d;
            tz1_q     <= tz1_d;
            tx2_q     <= tx2_d;
            tz2_q     <= tz2_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            d_valid_q <= d_valid_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d_idx_q   <= d_idx_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.d_valid = d_valid_q;
    assign bus.d0      = d0_q;
    assign bus.d1      = d1_q;
    assign bus.d2      = d2_q;
    assign bus.d_idx   = d_idx_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_turbo_encoder_ctrl.sv
// tb/tb_turbo_encoder_ctrl.sv - scoreboard bench for turbo_encoder_ctrl at K=40, 48 and 64
module tb_turbo_encoder_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_w [3];
    logic [63:0] din_w   [3];
    logic        ready_w [3];
    logic        v_w     [3];
    logic        d0_w    [3];
    logic        d1_w    [3];
    logic        d2_w    [3];
    logic        done_w  [3];
    logic [6:0]  idx_w   [3];
    logic [6:0]  pi_w    [3];
    logic [5:0]  st_w    [3];

    for (genvar n = 0; n < 3; n++) begin : g_cfg
        localparam int KG  = (n == 0) ? 40 : (n == 1) ? 48 : 64;
        localparam int F1G = (n == 0) ? 3 : 7;
        localparam int F2G = (n == 0) ? 10 : (n == 1) ? 12 : 16;
        turbo_encoder_ctrl_if #(.K(KG)) u_if ();
        turbo_encoder_ctrl #(.K(KG), .F1(F1G), .F2(F2G)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
        assign u_if.start = start_w[n];
        for (genvar j = 0; j < KG; j++) begin : g_din
            assign u_if.din[j] = din_w[n][j];
        end
        assign ready_w[n] = u_if.ready;
        assign v_w[n]     = u_if.d_valid;
        assign d0_w[n]    = u_if.d0;
        assign d1_w[n]    = u_if.d1;
        assign d2_w[n]    = u_if.d2;
        assign done_w[n]  = u_if.done;
        assign idx_w[n]   = 7'(u_if.d_idx);
        assign pi_w[n]    = 7'(u_dut.pi_q);
        assign st_w[n]    = {u_dut.enc2_q, u_dut.enc1_q};
    end

    typedef struct {
        logic       d0;
        logic       d1;
        logic       d2;
        logic [6:0] idx;
        logic       done;
    } exp_t;

    typedef struct {
        logic [63:0] din;
        logic [6:0]  idx;
        logic [2:0]  exp;
    } vec_t;

    exp_t        exp_q [3][$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          e0       [3];
    bit          have_prev[3];
    bit          b2b_chk  [3];
    int          acc_cnt  [3];
    int          done_cnt [3];
    bit [63:0]   seen     [3];
    int          reps     [3];
    vec_t        vt       [7];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int kof(input int n);
        return (n == 0) ? 40 : (n == 1) ? 48 : 64;
    endfunction

    function automatic int pi_ref(input int n, input int i);
        int f1, f2;
        f1 = (n == 0) ? 3 : 7;
        f2 = (n == 0) ? 10 : (n == 1) ? 12 : 16;
        return (f1 * i + f2 * i * i) % kof(n);
    endfunction

    // s = {s1, s2, s3}; returns {z, next state}
    function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic c);
        logic a;
        a = c ^ s[1] ^ s[0];
        return {a ^ s[2] ^ s[0], a, s[2], s[1]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_block(input int n, input logic [63:0] b);
        int         k;
        logic [2:0] s1, s2;
        logic [3:0] r1, r2;
        logic       x [2][3];
        logic       z [2][3];
        exp_t       e;
        k  = kof(n);
        s1 = 3'b000;
        s2 = 3'b000;
        for (int i = 0; i < k; i++) begin
            r1 = rsc_step(s1, b[i]);
            r2 = rsc_step(s2, b[pi_ref(n, i)]);
            s1 = r1[2:0];
            s2 = r2[2:0];
            e = '{d0: b[i], d1: r1[3], d2: r2[3], idx: 7'(i), done: 1'b0};
            exp_q[n].push_back(e);
        end
        for (int t = 0; t < 3; t++) begin
            x[0][t] = s1[1] ^ s1[0];
            x[1][t] = s2[1] ^ s2[0];
            r1 = rsc_step(s1, x[0][t]);
            r2 = rsc_step(s2, x[1][t]);
            z[0][t] = r1[3];
            z[1][t] = r2[3];
            s1 = r1[2:0];
            s2 = r2[2:0];
        end
        for (int j = 0; j < 4; j++) begin
            int m;
            m = j / 2;
            e.idx  = 7'(k + j);
            e.done = (j == 3);
            if (j % 2 == 0) begin
                e.d0 = x[m][0]; e.d1 = z[m][0]; e.d2 = x[m][1];
            end else begin
                e.d0 = z[m][1]; e.d1 = x[m][2]; e.d2 = z[m][2];
            end
            exp_q[n].push_back(e);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                int   k;
                exp_t e;
                k = kof(n);
                if (v_w[n]) begin
                    if (exp_q[n].size() == 0) begin
                        check($sformatf("unexpected_valid%0d", n), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[n].pop_front();
                        check($sformatf("stream%0d idx%0d", n, e.idx),
                              32'({d0_w[n], d1_w[n], d2_w[n], idx_w[n], done_w[n]}),
                              32'({e.d0, e.d1, e.d2, e.idx, e.done}));
                    end
                    if (int'(idx_w[n]) < k - 1) begin
                        check($sformatf("pi%0d i%0d", n, idx_w[n] + 7'd1), 32'(pi_w[n]),
                              32'(pi_ref(n, int'(idx_w[n]) + 1)));
                        if (seen[n][pi_w[n][5:0]]) reps[n]++;
                        seen[n][pi_w[n][5:0]] = 1'b1;
                    end
                end
                if (done_w[n]) begin
                    done_cnt[n]++;
                    check($sformatf("done_valid%0d", n), 32'(v_w[n]), 32'd1);
                    check($sformatf("done_time%0d", n), 32'(cyc - e0[n]), 32'(k + 7));
                    check($sformatf("tail_state%0d", n), 32'(st_w[n]), 32'd0);
                    check($sformatf("pi_perm%0d", n), 32'({reps[n][15:0], 16'($countones(seen[n]))}),
                          32'({16'd0, 16'(k)}));
                end
                if (ready_w[n] && !start_w[n]) have_prev[n] = 1'b0;
                if (rst && start_w[n] && ready_w[n]) begin
                    if (b2b_chk[n] && have_prev[n])
                        check($sformatf("b2b_period%0d", n), 32'(cyc + 1 - e0[n]), 32'(k + 8));
                    e0[n]        = cyc + 1;
                    have_prev[n] = 1'b1;
                    acc_cnt[n]++;
                    seen[n]      = 64'd1;
                    reps[n]      = 0;
                    push_block(n, din_w[n]);
                end
                if (!rst) begin
                    exp_q[n].delete();
                    have_prev[n] = 1'b0;
                end
            end
        end
    endtask

    task automatic run_block(input logic [63:0] b);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ready_w[0]) break;
        end
        @(posedge clk);
        #1;
        din_w[0]   = b;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
    endtask

    initial begin
        bit found;
        int target, t1, t2, dcount, pend;

        vt[0] = '{din: 64'd0,              idx: 7'd0,  exp: 3'b000};
        vt[1] = '{din: 64'd0,              idx: 7'd43, exp: 3'b000};
        vt[2] = '{din: 64'd1,              idx: 7'd0,  exp: 3'b111};
        vt[3] = '{din: 64'd1,              idx: 7'd1,  exp: 3'b011};
        vt[4] = '{din: 64'd1,              idx: 7'd2,  exp: 3'b011};
        vt[5] = '{din: 64'h0000_0000_2000, idx: 7'd1,  exp: 3'b001};
        vt[6] = '{din: 64'd2,              idx: 7'd1,  exp: 3'b110};

        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            start_w[n] = 1'b0;
            din_w[n]   = '0;
            b2b_chk[n] = 1'b0;
            acc_cnt[n] = 0;
            done_cnt[n] = 0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 3; n++)
            check($sformatf("reset_state%0d", n),
                  32'({ready_w[n], v_w[n], d0_w[n], d1_w[n], d2_w[n], idx_w[n], done_w[n]}), 32'h1000);
        @(negedge clk);
        for (int n = 0; n < 3; n++)
            check($sformatf("idle_after_release%0d", n), 32'({ready_w[n], v_w[n], done_w[n]}), 32'b100);

        for (int e = 0; e < 7; e++) begin
            run_block(vt[e].din);
            found = 1'b0;
            for (int c = 0; c < 100 && !found; c++) begin
                @(negedge clk);
                if (v_w[0] && idx_w[0] == vt[e].idx) begin
                    found = 1'b1;
                    check($sformatf("vec%0d", e), 32'({d0_w[0], d1_w[0], d2_w[0]}), 32'(vt[e].exp));
                end
            end
            if (!found) check($sformatf("vec%0d_timeout", e), 32'd0, 32'd1);
        end

        run_block({$urandom, $urandom});
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", 32'({ready_w[0], v_w[0], done_w[0]}), 32'b100);
        dcount = done_cnt[0];
        repeat (50) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt[0] - dcount), 32'd0);

        target     = acc_cnt[0] + 100;
        b2b_chk[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b1;
        for (int c = 0; c < 100 * 48 + 100; c++) begin
            din_w[0] = {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (acc_cnt[0] >= target) break;
        end
        start_w[0] = 1'b0;
        check("b2b_count", 32'(acc_cnt[0]), 32'(target));

        t1 = acc_cnt[1] + 8;
        t2 = acc_cnt[2] + 8;
        b2b_chk[1] = 1'b1;
        b2b_chk[2] = 1'b1;
        start_w[1] = 1'b1;
        start_w[2] = 1'b1;
        for (int c = 0; c < 2000 && (start_w[1] || start_w[2]); c++) begin
            din_w[1] = {$urandom, $urandom};
            din_w[2] = {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (acc_cnt[1] >= t1) start_w[1] = 1'b0;
            if (acc_cnt[2] >= t2) start_w[2] = 1'b0;
        end
        start_w[1] = 1'b0;
        start_w[2] = 1'b0;
        check("sweep_count48", 32'(acc_cnt[1]), 32'(t1));
        check("sweep_count64", 32'(acc_cnt[2]), 32'(t2));

        pend = 1;
        for (int c = 0; c < 300 && pend != 0; c++) begin
            @(negedge clk);
            pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        check("drain", 32'(pend), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
